// File: rtl/fsm_serial_tx.sv
// Parallel-to-serial bit-stream transmitter: loads a word plus bit count, then
// shifts the selected bits out MSB-first under receiver backpressure.
module fsm_serial_tx #(
    parameter int WIDTH = 8,
    parameter int LEN_W = 4,
    parameter int GAP   = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    input  logic [LEN_W-1:0] load_len,
    output logic             bit_out,
    output logic             bit_valid,
    input  logic             rx_ready,
    output logic             busy,
    output logic             done
);
    localparam int               GAP_W    = (GAP > 0) ? $clog2(GAP + 1) : 1;
    localparam logic [LEN_W-1:0] FULL_LEN = LEN_W'(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_GAP
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [LEN_W-1:0] remaining;
    logic [GAP_W-1:0] gap_cnt;
    logic [LEN_W-1:0] eff_len;
    logic [WIDTH-1:0] aligned;

    // Left-align the selected bits so the frame's first bit always sits at the MSB.
    // NOTE: every variable written here gets a default first, so no latch is inferred.
    always_comb begin
        eff_len = load_len;
        if (load_len == '0 || load_len > FULL_LEN) begin
            eff_len = FULL_LEN;
        end
        aligned = load_data << (FULL_LEN - eff_len);
    end

    // NOTE: state is updated with non-blocking assignments so every register samples
    // pre-edge values; the done default below is a registered pulse, not a latch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            shreg     <= '0;
            remaining <= '0;
            gap_cnt   <= '0;
            bit_out   <= 1'b0;
            bit_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (load_valid) begin
                        shreg     <= aligned;
                        remaining <= eff_len;
                        bit_out   <= aligned[WIDTH-1];
                        bit_valid <= 1'b1;
                        state     <= S_SEND;
                    end
                end
                S_SEND: begin
                    // bit_valid is always high in SEND, so rx_ready alone marks a transfer.
                    if (rx_ready) begin
                        if (remaining > LEN_W'(1)) begin
                            shreg     <= shreg << 1;
                            bit_out   <= shreg[WIDTH-2];
                            remaining <= remaining - LEN_W'(1);
                        end else begin
                            bit_out   <= 1'b0;
                            bit_valid <= 1'b0;
                            remaining <= '0;
                            if (GAP > 0) begin
                                gap_cnt <= GAP_W'(GAP);
                                state   <= S_GAP;
                            end else begin
                                done  <= 1'b1;
                                state <= S_IDLE;
                            end
                        end
                    end
                end
                S_GAP: begin
                    if (gap_cnt <= GAP_W'(1)) begin
                        gap_cnt <= '0;
                        done    <= 1'b1;
                        state   <= S_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - GAP_W'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign load_ready = (state == S_IDLE);
    assign busy       = (state != S_IDLE);

endmodule

// File: tb/tb_fsm_serial_tx.sv
// Scoreboard bench for fsm_serial_tx: two instances (GAP=0 and GAP=2) driven with
// directed and random frames, checked against a bit-queue reference model.
module tb_fsm_serial_tx;
    localparam int W    = 8;
    localparam int GAP1 = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] lv, lr, bo, bv, rx, bz, dn;
    logic [W-1:0] ld [2];
    logic [3:0]   ll [2];

    // Expected stream per instance: 0/1 are bits, 2 marks the end of a frame.
    int   q0[$];
    int   q1[$];
    int   wd[2];
    int   vcnt[2];
    int   last_vcnt[2];
    bit   held[2];
    logic prev_bo[2];
    bit   rand_rx[2];
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    fsm_serial_tx #(.WIDTH(W), .LEN_W(4), .GAP(0)) u_tx0 (
        .clk(clk), .reset(reset), .load_valid(lv[0]), .load_ready(lr[0]),
        .load_data(ld[0]), .load_len(ll[0]), .bit_out(bo[0]), .bit_valid(bv[0]),
        .rx_ready(rx[0]), .busy(bz[0]), .done(dn[0])
    );

    fsm_serial_tx #(.WIDTH(W), .LEN_W(4), .GAP(GAP1)) u_tx1 (
        .clk(clk), .reset(reset), .load_valid(lv[1]), .load_ready(lr[1]),
        .load_data(ld[1]), .load_len(ll[1]), .bit_out(bo[1]), .bit_valid(bv[1]),
        .rx_ready(rx[1]), .busy(bz[1]), .done(dn[1])
    );

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s[%0d]: got %0h expected %0h at %0t", name, idx, act, want, $time);
        end
    endtask

    function automatic int qsize(input int i);
        return (i == 0) ? q0.size() : q1.size();
    endfunction

    function automatic int front(input int i);
        return (i == 0) ? q0[0] : q1[0];
    endfunction

    function automatic int pop(input int i);
        return (i == 0) ? q0.pop_front() : q1.pop_front();
    endfunction

    task automatic push(input int i, input int v);
        if (i == 0) q0.push_back(v);
        else        q1.push_back(v);
    endtask

    // Reference model: effective length, then bits L-1 down to 0, then end marker.
    task automatic expect_frame(input int i, input logic [W-1:0] data, input int len);
        int l;
        l = (len == 0 || len > W) ? W : len;
        for (int k = l - 1; k >= 0; k--) push(i, int'(data[k]));
        push(i, 2);
    endtask

    task automatic mon(input int i);
        int item;
        int gap;
        gap = (i == 0) ? 0 : GAP1;
        if (wd[i] > 0) begin
            wd[i]--;
            if (wd[i] == 0) begin
                check("done", i, dn[i], 1);
                check("ready_at_done", i, lr[i], 1);
                last_vcnt[i] = vcnt[i];
                vcnt[i]      = 0;
                void'(pop(i));
            end else begin
                check("gap_valid", i, bv[i], 0);
                check("gap_busy", i, bz[i], 1);
                check("gap_ready", i, lr[i], 0);
                check("gap_done", i, dn[i], 0);
            end
        end else begin
            check("done_idle", i, dn[i], 0);
        end
        check("busy_vs_ready", i, bz[i], !lr[i]);
        if (held[i]) begin
            check("hold_valid", i, bv[i], 1);
            check("hold_bit", i, bo[i], prev_bo[i]);
        end
        if (!bv[i]) check("zero_when_invalid", i, bo[i], 0);
        else        vcnt[i]++;
        if (bv[i] && rx[i]) begin
            if (qsize(i) == 0) begin
                check("unexpected_xfer", i, bv[i], 0);
            end else begin
                item = pop(i);
                check("bit", i, bo[i], item);
                if (qsize(i) > 0 && front(i) == 2) wd[i] = gap + 1;
            end
        end
        held[i]    = bv[i] && !rx[i];
        prev_bo[i] = bo[i];
    endtask

    always @(negedge clk) begin
        if (reset) begin
            q0.delete();
            q1.delete();
            for (int i = 0; i < 2; i++) begin
                wd[i]   = 0;
                vcnt[i] = 0;
                held[i] = 1'b0;
            end
        end else begin
            for (int i = 0; i < 2; i++) mon(i);
        end
    end

    always @(posedge clk) begin
        #1;
        for (int i = 0; i < 2; i++) if (rand_rx[i]) rx[i] = ($urandom_range(0, 3) != 0);
    end

    task automatic wait_drain(input int i);
        int n;
        n = 0;
        while ((qsize(i) != 0 || wd[i] != 0) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", i, (qsize(i) != 0 || wd[i] != 0), 0);
    endtask

    task automatic send(input int i, input logic [W-1:0] data, input int len);
        expect_frame(i, data, len);
        @(posedge clk); #1;
        lv[i] = 1'b1;
        ld[i] = data;
        ll[i] = 4'(len);
        @(posedge clk); #1;
        lv[i] = 1'b0;
        check("first_bit_latency", i, bv[i], 1);
    endtask

    task automatic check_reset_outputs(input int i);
        check("rst_bit_out", i, bo[i], 0);
        check("rst_bit_valid", i, bv[i], 0);
        check("rst_busy", i, bz[i], 0);
        check("rst_done", i, dn[i], 0);
        check("rst_load_ready", i, lr[i], 1);
    endtask

    initial begin
        reset   = 1'b1;
        lv      = '0;
        rx      = '1;
        rand_rx = '{1'b0, 1'b0};
        ld[0] = '0; ld[1] = '0;
        ll[0] = '0; ll[1] = '0;
        #1;
        check_reset_outputs(0);
        check_reset_outputs(1);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Full-width frame, then short and over-long lengths.
        send(0, 8'hB2, 0);
        wait_drain(0);
        check("valid_cycles_b2", 0, last_vcnt[0], 8);
        send(0, 8'hF5, 3);
        wait_drain(0);
        check("valid_cycles_len3", 0, last_vcnt[0], 3);
        send(0, 8'hF5, 9);
        wait_drain(0);
        check("valid_cycles_len9", 0, last_vcnt[0], 8);

        // Backpressure for two cycles while the 4th bit is presented.
        expect_frame(0, 8'hA5, 8);
        @(posedge clk); #1;
        lv[0] = 1'b1; ld[0] = 8'hA5; ll[0] = 4'd8;
        @(posedge clk); #1;
        lv[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1 rx[0] = 1'b0;
        check("stall_bit", 0, bo[0], 0);
        repeat (2) @(posedge clk);
        #1 rx[0] = 1'b1;
        wait_drain(0);
        check("valid_cycles_stall", 0, last_vcnt[0], 10);

        // GAP=2 instance with a load pulse landing inside the gap.
        expect_frame(1, 8'hFF, 0);
        @(posedge clk); #1;
        lv[1] = 1'b1; ld[1] = 8'hFF; ll[1] = 4'd0;
        @(posedge clk); #1;
        lv[1] = 1'b0;
        repeat (8) @(posedge clk);
        #1 lv[1] = 1'b1; ld[1] = 8'h00;
        @(posedge clk);
        #1 lv[1] = 1'b0;
        wait_drain(1);
        check("valid_cycles_gap", 1, last_vcnt[1], 8);

        // Asynchronous reset mid-frame, with a load requested while reset is held.
        expect_frame(0, 8'hC3, 0);
        @(posedge clk); #1;
        lv[0] = 1'b1; ld[0] = 8'hC3; ll[0] = 4'd0;
        @(posedge clk); #1;
        lv[0] = 1'b0;
        repeat (4) @(posedge clk);
        #3 reset = 1'b1;
        #1 check_reset_outputs(0);
        lv[0] = 1'b1; ld[0] = 8'hFF;
        @(posedge clk);
        #1 reset = 1'b0; lv[0] = 1'b0;
        #1 check("load_during_reset", 0, bv[0], 0);
        check("ready_after_reset", 0, lr[0], 1);
        send(0, 8'h3C, 0);
        wait_drain(0);
        check("valid_cycles_3c", 0, last_vcnt[0], 8);

        // load_valid held high: three back-to-back frames, one idle cycle apart.
        for (int n = 0; n < 3; n++) expect_frame(0, 8'h81, 0);
        @(posedge clk); #1;
        lv[0] = 1'b1; ld[0] = 8'h81; ll[0] = 4'd0;
        repeat (27) @(posedge clk);
        #1 lv[0] = 1'b0;
        wait_drain(0);
        check("valid_cycles_81", 0, last_vcnt[0], 8);

        // Random frames and random receiver backpressure on both instances.
        rand_rx = '{1'b1, 1'b1};
        for (int n = 0; n < 30; n++) begin
            int i;
            i = n % 2;
            send(i, W'($urandom), int'($urandom_range(0, 15)));
            wait_drain(i);
        end
        rand_rx = '{1'b0, 1'b0};
        @(posedge clk);
        #1 rx = '1;
        repeat (3) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
